// File: rtl/aes_encrypt_iter.sv
// aes_encrypt_iter: iterative AES-128 encryption core.
// One AES round per clock with on-the-fly key expansion. A block is accepted
// in IDLE, runs ten rounds in ROUND, and is presented in DONE until the sink
// takes it. The ciphertext is driven straight from the state register.
module aes_encrypt_iter #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out,
   output logic         busy
);

   // Only the AES-128 round count is implemented.
   generate
      if (NR != 10) begin : g_nr_check
         $error("aes_encrypt_iter: only NR = 10 (AES-128) is supported");
      end
   endgenerate

   localparam logic [3:0] LAST_ROUND = 4'(NR);

   // FIPS-197 forward S-box.
   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1 (0x11b).
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Round constant for the round about to be computed (counter 1..10).
   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      logic [7:0] rc;
      case (rnd)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   // SubBytes: S-box applied to every byte (position independent).
   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] r;
      r = 128'h0;
      for (int i = 0; i < 16; i++) begin
         r[8*i +: 8] = SBOX[s[8*i +: 8]];
      end
      return r;
   endfunction

   // ShiftRows: row r of the column-major state rotates left by r columns.
   // Byte k lives at bits [127-8k -: 8], with k = 4*column + row.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] r;
      int           src;
      r = 128'h0;
      for (int c = 0; c < 4; c++) begin
         for (int rw = 0; rw < 4; rw++) begin
            src = 4 * ((c + rw) % 4) + rw;
            r[127 - 8*(4*c + rw) -: 8] = s[127 - 8*src -: 8];
         end
      end
      return r;
   endfunction

   // MixColumns on each of the four columns.
   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a0, a1, a2, a3;
      r = 128'h0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         r[127 - 32*c -: 8] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
         r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
         r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
         r[103 - 32*c -: 8] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
      end
      return r;
   endfunction

   // One step of the AES-128 key schedule from the current round key.
   function automatic logic [127:0] next_round_key(input logic [127:0] rk,
                                                   input logic [7:0]   rc);
      logic [31:0] w0, w1, w2, w3, rot, temp, n0, n1, n2, n3;
      w0   = rk[127:96];
      w1   = rk[95:64];
      w2   = rk[63:32];
      w3   = rk[31:0];
      rot  = {w3[23:0], w3[31:24]};
      temp = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]}
             ^ {rc, 24'h000000};
      n0   = w0 ^ temp;
      n1   = w1 ^ n0;
      n2   = w2 ^ n1;
      n3   = w3 ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   state_e        fsm_q, fsm_d;
   logic [127:0]  blk_q, blk_d;
   logic [127:0]  rk_q, rk_d;
   logic [3:0]    cnt_q, cnt_d;

   logic [127:0]  sr_s;
   logic [127:0]  mc_s;
   logic [127:0]  rk_next_s;

   // Round datapath: SubBytes/ShiftRows, MixColumns and the next round key.
   always_comb begin
      sr_s      = shift_rows(sub_bytes(blk_q));
      mc_s      = mix_columns(sr_s);
      rk_next_s = next_round_key(rk_q, rcon(cnt_q));
   end

   // Next-state logic for the FSM and the block/key/counter registers.
   always_comb begin
      fsm_d = fsm_q;
      blk_d = blk_q;
      rk_d  = rk_q;
      cnt_d = cnt_q;
      case (fsm_q)
         IDLE: begin
            if (in_valid) begin
               blk_d = in ^ key;
               rk_d  = key;
               cnt_d = 4'd1;
               fsm_d = ROUND;
            end else begin
               fsm_d = IDLE;
            end
         end
         ROUND: begin
            rk_d  = rk_next_s;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAST_ROUND) begin
               // Final round has no MixColumns.
               blk_d = sr_s ^ rk_next_s;
               fsm_d = DONE;
            end else begin
               blk_d = mc_s ^ rk_next_s;
               fsm_d = ROUND;
            end
         end
         DONE: begin
            if (out_ready) begin
               fsm_d = IDLE;
            end else begin
               fsm_d = DONE;
            end
         end
         default: begin
            fsm_d = IDLE;
         end
      endcase
   end

   // State registers; reset clears everything and aborts any block in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q <= IDLE;
         blk_q <= 128'h0;
         rk_q  <= 128'h0;
         cnt_q <= 4'd0;
      end else begin
         fsm_q <= fsm_d;
         blk_q <= blk_d;
         rk_q  <= rk_d;
         cnt_q <= cnt_d;
      end
   end

   assign in_ready  = (fsm_q == IDLE);
   assign busy      = (fsm_q != IDLE);
   assign out_valid = (fsm_q == DONE);
   assign out       = blk_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed testbench for aes_encrypt_iter using FIPS-197 / SP800-38A vectors.
module tb_aes_encrypt_iter;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         out_ready;
   logic [127:0] in_d;
   logic [127:0] key_d;
   logic         in_ready;
   logic         out_valid;
   logic         busy;
   logic [127:0] out_w;

   int tests_run    = 0;
   int tests_failed = 0;

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] C0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   always #5 clk = ~clk;

   aes_encrypt_iter #(.NR(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (in_d),
      .key       (key_d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out_w),
      .busy      (busy)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Count edges until out_valid is seen; -1 if it never rises within budget.
   task automatic wait_valid(output int n);
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (out_valid === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   // Present one block for exactly one edge (caller ensures the DUT is IDLE).
   task automatic start_block(input logic [127:0] k, input logic [127:0] p);
      in_d     = p;
      key_d    = k;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_d = 128'h0; key_d = 128'h0;
      step();
      step();
      tests_run++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_ready_busy: in_ready=%b busy=%b, want 1 0", in_ready, busy);
      end
      tests_run++;
      if (out_valid !== 1'b0 || out_w !== 128'h0) begin
         tests_failed++;
         $display("FAIL reset_out: out_valid=%b out=%h, want 0 0", out_valid, out_w);
      end
      rst = 1'b0;
   endtask

   task automatic test_scenario1();
      int n;
      out_ready = 1'b1;
      start_block(K1, P1);   // first edge after reset release
      tests_run++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL first_accept: in_ready=%b busy=%b, want 0 1", in_ready, busy);
      end
      wait_valid(n);
      tests_run++;
      if (n !== 10) begin
         tests_failed++;
         $display("FAIL s1_latency: got %0d edges, want 10", n);
      end
      tests_run++;
      if (out_w !== C1) begin
         tests_failed++;
         $display("FAIL s1_out: got %h want %h", out_w, C1);
      end
      step();
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL s1_one_cycle: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_hold();
      int n;
      bit hold_ok;
      out_ready = 1'b0;
      start_block(128'h0, 128'h0);
      wait_valid(n);
      tests_run++;
      if (out_w !== C0) begin
         tests_failed++;
         $display("FAIL s3_out: got %h want %h", out_w, C0);
      end
      hold_ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_w !== C0) hold_ok = 1'b0;
      end
      tests_run++;
      if (hold_ok !== 1'b1) begin
         tests_failed++;
         $display("FAIL s3_hold: output not held, out_valid=%b in_ready=%b out=%h", out_valid, in_ready, out_w);
      end
      out_ready = 1'b1;
      step();
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL s3_release: out_valid=%b in_ready=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
      end
   endtask

   task automatic test_ignore_inflight();
      int n;
      int extra;
      out_ready = 1'b1;
      start_block(K1, P1);
      step();
      step();
      in_d     = P2;
      key_d    = K2;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      in_d     = ~128'h0;
      key_d    = ~128'h0;
      wait_valid(n);
      tests_run++;
      if (n !== 7) begin
         tests_failed++;
         $display("FAIL s4_latency: got %0d more edges, want 7", n);
      end
      tests_run++;
      if (out_w !== C1) begin
         tests_failed++;
         $display("FAIL s4_out: got %h want %h", out_w, C1);
      end
      extra = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (out_valid === 1'b1) extra++;
      end
      tests_run++;
      if (extra !== 0) begin
         tests_failed++;
         $display("FAIL s4_single_output: got %0d extra valid cycles, want 0", extra);
      end
   endtask

   task automatic test_reset_abort();
      int n;
      int seen;
      out_ready = 1'b1;
      start_block(K1, P1);
      repeat (4) step();
      rst = 1'b1;
      #2;
      tests_run++;
      if (out_valid !== 1'b0 || out_w !== 128'h0) begin
         tests_failed++;
         $display("FAIL s5_abort_out: out_valid=%b out=%h, want 0 0", out_valid, out_w);
      end
      tests_run++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL s5_abort_ready: in_ready=%b busy=%b, want 1 0", in_ready, busy);
      end
      step();
      step();
      rst  = 1'b0;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (out_valid === 1'b1) seen++;
      end
      tests_run++;
      if (seen !== 0) begin
         tests_failed++;
         $display("FAIL s5_no_pulse: got %0d valid cycles, want 0", seen);
      end
      start_block(K2, P2);
      wait_valid(n);
      tests_run++;
      if (n !== 10 || out_w !== C2) begin
         tests_failed++;
         $display("FAIL s5_next_block: latency %0d out %h, want 10 %h", n, out_w, C2);
      end
      step();
   endtask

   task automatic test_back_to_back();
      int n;
      out_ready = 1'b1;
      in_d      = P1;
      key_d     = K1;
      in_valid  = 1'b1;
      step();                 // first accept
      in_d  = P2;
      key_d = K2;             // in_valid stays high
      wait_valid(n);
      tests_run++;
      if (n !== 10 || out_w !== C1) begin
         tests_failed++;
         $display("FAIL b2b_first: latency %0d out %h, want 10 %h", n, out_w, C1);
      end
      step();                 // output handshake edge
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_idle: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      end
      step();                 // second accept
      tests_run++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_second_accept: in_ready=%b busy=%b, want 0 1", in_ready, busy);
      end
      in_valid = 1'b0;
      wait_valid(n);
      tests_run++;
      if (n !== 10 || out_w !== C2) begin
         tests_failed++;
         $display("FAIL b2b_second: latency %0d out %h, want 10 %h", n, out_w, C2);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_scenario1();
      test_hold();
      test_ignore_inflight();
      test_reset_abort();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, limit 200000 time units");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/aes_encrypt_iter.md
AES_ENCRYPT_ITER -- requirements
Module: aes_encrypt_iter

Interface
REQ-001 Parameter NR, default 10, meaning AES round count; only 10 (AES-128) SHALL be supported, and any other value SHALL be a elaboration-time error.
REQ-002 clk  input  1  single clock; all state updates SHALL occur on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  SHALL indicate that in and key carry a block to encrypt.
REQ-005 in_ready  output  1  SHALL indicate that the block is idle and will accept a block.
REQ-006 in  input  128  plaintext; in[127:120] SHALL be FIPS-197 byte 0, with column-major state order.
REQ-007 key  input  128  cipher key, same byte order as in.
REQ-008 out_valid  output  1  SHALL indicate that out holds a finished ciphertext.
REQ-009 out_ready  input  1  SHALL indicate that the sink consumes out.
REQ-010 out  output  128  ciphertext, same byte order as in.
REQ-011 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, ROUND and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE.
REQ-014 Accept SHALL be defined as in_valid & in_ready on a rising edge.
REQ-015 On accept: state <= in ^ key; round key register <= key; round counter <= 1; FSM -> ROUND.
REQ-016 The block SHALL sample in and key only on the accept edge; later changes SHALL have no effect.
REQ-017 ROUND SHALL perform exactly one AES round per cycle: SubBytes, ShiftRows, MixColumns (skipped when counter = 10), then AddRoundKey with the next round key.
REQ-018 The next round key SHALL be derived on the fly from the current round-key register using RotWord, SubWord and Rcon[counter], where Rcon = 01,02,04,08,10,20,40,80,1b,36; no full expanded key storage.
REQ-019 The round counter SHALL be 4 bits and SHALL increment each ROUND cycle.
REQ-020 On the edge that completes round 10, the FSM SHALL go to DONE and out_valid SHALL rise.
REQ-021 Latency SHALL be exactly 10 clock edges from the accept edge to the edge at which out_valid becomes 1.
REQ-022 Throughput SHALL be at most one block per 11 cycles when out_ready is held at 1.
REQ-023 In DONE, out_valid SHALL stay 1 and out SHALL stay constant until out_ready = 1.
REQ-024 On an edge in DONE with out_ready = 1, the FSM SHALL go to IDLE and out_valid SHALL fall.
REQ-025 A new block SHALL be accepted no earlier than the following edge.
REQ-026 in_valid during ROUND or DONE SHALL be ignored, with no queuing and no corruption of the block in flight.
REQ-027 out_ready while out_valid = 0 SHALL have no effect.
REQ-028 out SHALL be driven directly from the state register, with no combinational path from in or key to out.
REQ-029 The S-box SHALL be the FIPS-197 forward S-box.
REQ-030 MixColumns SHALL use GF(2^8) multiplication with polynomial 0x11b.

Reset
REQ-031 While rst = 1, the FSM SHALL be IDLE, with in_ready = 1 and busy = 0.
REQ-032 While rst = 1, out_valid SHALL be 0.
REQ-033 While rst = 1, out, the state register, the round-key register and the counter SHALL be 0.
REQ-034 Reset asserted mid-ROUND or in DONE SHALL abort the block immediately, and no out_valid pulse SHALL follow.
REQ-035 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-036 Scenario 1: key 000102030405060708090a0b0c0d0e0f, in 00112233445566778899aabbccddeeff, out_ready = 1 -> out = 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid high 10 edges after accept, for one cycle.
REQ-037 Scenario 2: key 2b7e151628aed2a6abf7158809cf4f3c, in 3243f6a8885a308d313198a2e0370734 -> out = 3925841d02dc09fbdc118597196a0b32.
REQ-038 Scenario 3: key 0 and in 0; hold out_ready = 0 for 20 cycles after out_valid -> out stays 66e94bd4ef8a2c3b884cfa59ca342b2e, out_valid stays 1 and in_ready stays 0; then out_ready = 1 -> IDLE on the next edge.
REQ-039 Scenario 4: start the Scenario 1 block, then change in and key and pulse in_valid during ROUND -> the result is still 69c4e0d86a7b0430d8cdb78070b4c55a and there is exactly one output.
REQ-040 Scenario 5: assert rst at round 5 of a block -> out_valid never rises for it, all outputs read 0 and in_ready = 1; the next block (Scenario 2) returns the correct ciphertext.
REQ-041 Scenario 6: issue Scenarios 1 and 2 back-to-back with in_valid held high -> the second accept occurs on the edge after the first output handshake, and both results are correct.
